// File: rtl/nyaya_vec_alu.sv
// Multi-lane Catuskoti ALU: one opcode over LANES 2-bit lanes, registered output, per-lane oscillation lock.
// Optional macro NYAYA_VEC_STATS_EN adds a saturating loop_events counter output.
module nyaya_vec_alu #(
    parameter int LANES       = 8,
    parameter int LOOP_THRESH = 8,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef NYAYA_VEC_STATS_EN
    output logic [15:0]          loop_events,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*LANES-1:0]   op_a,
    input  logic [2*LANES-1:0]   op_b,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*LANES-1:0]   result,
    output logic [LANES-1:0]     loop_mask,
    input  logic                 clear_loops
);

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NOT   = 3'd2,
        OP_XOR   = 3'd3,
        OP_IMPL  = 3'd4,
        OP_EQUIV = 3'd5,
        OP_BOTH  = 3'd6,
        OP_NULL  = 3'd7
    } op_t;

    localparam logic [1:0] ASATYA   = 2'b00;
    localparam logic [1:0] SATYA    = 2'b01;
    localparam logic [1:0] UBHAYA   = 2'b10;
    localparam logic [1:0] ANUBHAYA = 2'b11;

    localparam logic [CNT_W:0] THRESH = (CNT_W+1)'(LOOP_THRESH);

    function automatic logic [1:0] f_not(input logic [1:0] a);
        logic [1:0] y;
        y = a;
        if (a == ASATYA)     y = SATYA;
        else if (a == SATYA) y = ASATYA;
        return y;
    endfunction

    function automatic logic [1:0] f_and(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] y;
        if (a == ANUBHAYA || b == ANUBHAYA)    y = ANUBHAYA;
        else if (a == ASATYA || b == ASATYA)   y = ASATYA;
        else if (a == UBHAYA || b == UBHAYA)   y = UBHAYA;
        else                                   y = SATYA;
        return y;
    endfunction

    function automatic logic [1:0] f_or(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] y;
        if (a == SATYA || b == SATYA)          y = SATYA;
        else if (a == UBHAYA || b == UBHAYA)   y = UBHAYA;
        else if (a == ANUBHAYA || b == ANUBHAYA) y = ANUBHAYA;
        else                                   y = ASATYA;
        return y;
    endfunction

    function automatic logic [1:0] f_xor(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] y;
        if (a == b)                            y = ASATYA;
        else if (a == UBHAYA || b == UBHAYA)   y = UBHAYA;
        else if (a == ANUBHAYA || b == ANUBHAYA) y = ANUBHAYA;
        else                                   y = SATYA;
        return y;
    endfunction

    function automatic logic [1:0] f_lane(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        logic [1:0] y;
        case (op_t'(op))
            OP_AND:   y = f_and(a, b);
            OP_OR:    y = f_or(a, b);
            OP_NOT:   y = f_not(a);
            OP_XOR:   y = f_xor(a, b);
            OP_IMPL:  y = f_or(f_not(a), b);
            OP_EQUIV: y = (a == b) ? SATYA : ASATYA;
            OP_BOTH:  y = UBHAYA;
            default:  y = ANUBHAYA;
        endcase
        return y;
    endfunction

    logic                        accept;
    logic [LANES-1:0][1:0]       hist, hist_n;
    logic [LANES-1:0][CNT_W-1:0] cnt, cnt_n;
    logic [LANES-1:0]            looped, looped_n;
    logic [LANES-1:0]            entry;
    logic [LANES-1:0][1:0]       res_n;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A coinciding clear_loops makes the lane see freshly cleared history.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [1:0]       r, h;
        logic [CNT_W-1:0] c;
        logic             l, alt, hit;

        assign r   = f_lane(opcode, op_a[2*i +: 2], op_b[2*i +: 2]);
        assign h   = clear_loops ? ANUBHAYA : hist[i];
        assign c   = clear_loops ? '0 : cnt[i];
        assign l   = clear_loops ? 1'b0 : looped[i];
        assign alt = !h[1] && !r[1] && (h != r);
        assign hit = alt && (({1'b0, c} + (CNT_W+1)'(1)) == THRESH);

        assign hist_n[i]   = r;
        assign cnt_n[i]    = (alt && !hit) ? c + CNT_W'(1) : '0;
        assign looped_n[i] = l || hit;
        assign entry[i]    = hit && !l;
        assign res_n[i]    = looped_n[i] ? UBHAYA : r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist   <= '1;
            cnt    <= '0;
            looped <= '0;
        end else if (accept) begin
            hist   <= hist_n;
            cnt    <= cnt_n;
            looped <= looped_n;
        end else if (clear_loops) begin
            hist   <= '1;
            cnt    <= '0;
            looped <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            loop_mask <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= res_n;
            loop_mask <= looped_n;
        end else begin
            if (out_ready)   out_valid <= 1'b0;
            if (clear_loops) loop_mask <= '0;
        end
    end

`ifdef NYAYA_VEC_STATS_EN
    logic [31:0] entry_cnt, ev_sum;

    always_comb begin
        entry_cnt = '0;
        for (int i = 0; i < LANES; i++) entry_cnt = entry_cnt + 32'(entry[i]);
        ev_sum = 32'(loop_events) + entry_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         loop_events <= '0;
        else if (accept) loop_events <= (ev_sum > 32'h0000_FFFF) ? 16'hFFFF : ev_sum[15:0];
    end
`else
    logic unused_entry;
    assign unused_entry = ^entry;
`endif

endmodule

// File: tb/tb_nyaya_vec_alu.sv
// Directed bench for nyaya_vec_alu (LANES=4, LOOP_THRESH=3) with a result/loop_mask scoreboard.
// Also checks loop_events when NYAYA_VEC_STATS_EN is defined.
module tb_nyaya_vec_alu;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_NOT   = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_IMPL  = 3'd4;
    localparam logic [2:0] OP_EQUIV = 3'd5;
    localparam logic [2:0] OP_BOTH  = 3'd6;
    localparam logic [2:0] OP_NULL  = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] loop_mask;
    logic       clear_loops;
`ifdef NYAYA_VEC_STATS_EN
    logic [15:0] loop_events;
`endif

    int compared   = 0;
    int mismatched = 0;
    int out_idx    = 0;
    logic [11:0] sb[$];

    nyaya_vec_alu #(.LANES(4), .LOOP_THRESH(3), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
`ifdef NYAYA_VEC_STATS_EN
        .loop_events(loop_events),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op_a(op_a),
        .op_b(op_b),
        .opcode(opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .loop_mask(loop_mask),
        .clear_loops(clear_loops)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every output transfer is compared against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", {20'd0, result, loop_mask}, 32'hFFFF_FFFF);
            end else begin
                checkOutput($sformatf("out%0d", out_idx), {20'd0, result, loop_mask}, {20'd0, sb.pop_front()});
                out_idx++;
            end
        end
    end

    // Drive one transaction, queue its expected result, and hold until it is accepted.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic clr, input logic [7:0] exp_res, input logic [3:0] exp_mask);
        logic ok;
        ok = 1'b0;
        opcode      = op;
        op_a        = a;
        op_b        = b;
        clear_loops = clr;
        in_valid    = 1'b1;
        sb.push_back({exp_res, exp_mask});
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid    = 1'b0;
        clear_loops = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(tag, sb.size(), 32'd0);
    endtask

    task automatic pulseClear();
        clear_loops = 1'b1;
        @(posedge clk);
        #1;
        clear_loops = 1'b0;
        checkOutput("clear_mask", {28'd0, loop_mask}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; opcode = '0;
        out_ready = 1'b1; clear_loops = 1'b0;
        #2;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_result", {24'd0, result}, 32'd0);
        checkOutput("rst_mask", {28'd0, loop_mask}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lane0 alternates under NOT and locks on the third alternation.
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h55, 4'h0);
        applyStimulus(OP_NOT, 8'h01, 8'h00, 1'b0, 8'h54, 4'h0);
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h55, 4'h0);
        applyStimulus(OP_NOT, 8'h01, 8'h00, 1'b0, 8'h56, 4'h1);
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h56, 4'h1);
        waitDrain("drain_loop1");

        // An indefinite value in the middle breaks the alternation run.
        pulseClear();
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h55, 4'h0);
        applyStimulus(OP_NOT, 8'h01, 8'h00, 1'b0, 8'h54, 4'h0);
        applyStimulus(OP_NOT, 8'h02, 8'h00, 1'b0, 8'h56, 4'h0);
        applyStimulus(OP_NOT, 8'h01, 8'h00, 1'b0, 8'h54, 4'h0);
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h55, 4'h0);
        applyStimulus(OP_NOT, 8'h01, 8'h00, 1'b0, 8'h54, 4'h0);

        // Lock, then clear together with an accept; three more alternations re-lock.
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h56, 4'h1);
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b1, 8'h55, 4'h0);
        applyStimulus(OP_NOT, 8'h01, 8'h00, 1'b0, 8'h54, 4'h0);
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h55, 4'h0);
        applyStimulus(OP_NOT, 8'h01, 8'h00, 1'b0, 8'h56, 4'h1);
        waitDrain("drain_clear");

        // Stall a looped result, then reset while it is pending.
        out_ready = 1'b0;
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h56, 4'h1);
        checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_result", {24'd0, result}, 32'h56);
        checkOutput("stall_mask", {28'd0, loop_mask}, 32'h1);
        checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_result", {24'd0, result}, 32'd0);
        checkOutput("mid_rst_mask", {28'd0, loop_mask}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // History is indefinite after reset, so three steps do not lock.
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h55, 4'h0);
        applyStimulus(OP_NOT, 8'h01, 8'h00, 1'b0, 8'h54, 4'h0);
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h55, 4'h0);
        waitDrain("drain_post_rst");

        // Backpressure holds the AND result; release with a queued OR gives no bubble.
        out_ready = 1'b0;
        applyStimulus(OP_AND, 8'h55, 8'hAA, 1'b0, 8'hAA, 4'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp_valid%0d", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("bp_result%0d", i), {24'd0, result}, 32'hAA);
            checkOutput($sformatf("bp_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(OP_OR, 8'h55, 8'h00, 1'b0, 8'h55, 4'h0);
        checkOutput("no_gap_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("no_gap_result", {24'd0, result}, 32'h55);
        waitDrain("drain_bp");

        // Remaining opcodes with mixed lane values.
        applyStimulus(OP_BOTH,  8'h00, 8'h00, 1'b0, 8'hAA, 4'h0);
        applyStimulus(OP_NULL,  8'h00, 8'h00, 1'b0, 8'hFF, 4'h0);
        applyStimulus(OP_EQUIV, 8'h39, 8'h7D, 1'b0, 8'h11, 4'h0);
        applyStimulus(OP_XOR,   8'h39, 8'h04, 1'b0, 8'h39, 4'h0);
        applyStimulus(OP_IMPL,  8'hE4, 8'h30, 1'b0, 8'hE1, 4'h0);
        applyStimulus(OP_AND,   8'h93, 8'h58, 1'b0, 8'h93, 4'h0);
        applyStimulus(OP_OR,    8'hF8, 8'h7C, 1'b0, 8'h78, 4'h0);
        waitDrain("drain_ops");

        // All four lanes lock on the same transaction.
        pulseClear();
`ifdef NYAYA_VEC_STATS_EN
        checkOutput("events_before", {16'd0, loop_events}, 32'd0);
`endif
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h55, 4'h0);
        applyStimulus(OP_NOT, 8'h55, 8'h00, 1'b0, 8'h00, 4'h0);
        applyStimulus(OP_NOT, 8'h00, 8'h00, 1'b0, 8'h55, 4'h0);
        applyStimulus(OP_NOT, 8'h55, 8'h00, 1'b0, 8'hAA, 4'hF);
        waitDrain("drain_all_lanes");
`ifdef NYAYA_VEC_STATS_EN
        checkOutput("events_after", {16'd0, loop_events}, 32'd4);
        pulseClear();
        checkOutput("events_kept", {16'd0, loop_events}, 32'd4);
`else
        pulseClear();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
